rx_core: RTL and testbench
==========================

// Module: rx_core
// PURPOSE
// - Receive-side counterpart of tx_core: consumes the 128-bit RF-ADC stream (8 signed 16-bit samples/clock), applies a digital gain,
//   decimates by 8*2^dec_log2 via an 8-lane sum plus a boxcar integrator, and delivers results over a valid/ready stream buffered in a small FIFO.
// - Also reports interval_max: peak |sample| per programmable interval, for AGC/level monitoring by the PS.
// PARAMETERS
// - FIFO_DEPTH  4   result FIFO entries (power of two, >=2)
// - MAX_DEC_LOG2 10 largest accepted dec_log2; larger values clamp to this
// PORTS
// - clock              in   1    sole clock (RF-ADC fabric clock)
// - reset              in   1    synchronous, active-high
// - rx_gain            in   8    unsigned Q4.4 gain (0x10 = 1.0)
// - dec_log2           in   4    integrator length = 2^dec_log2 blocks
// - interval_len       in   16   valid cycles per peak interval; 0 treated as 1
// - clear_overflow     in   1    one-cycle pulse clears overflow
// - adc_data           in   128  lane k = bits[16k+15:16k], lane 0 = oldest sample
// - adc_valid          in   1    adc_data qualifier
// - m_data             out  32   signed decimated result
// - m_valid            out  1    FIFO non-empty
// - m_ready            in   1    consumer accept
// - overflow           out  1    sticky: a result was dropped on full FIFO
// - interval_max       out  16   peak |gained sample| of last completed interval
// - interval_max_valid out  1    one-cycle pulse when interval_max updates
// BEHAVIOUR
// - Reset: all outputs 0; FIFO empty; integrator, block counter, interval counter and running peak cleared. Reset mid-window discards partials.
// - S1 (gain, reg): g = sat16((lane * rx_gain) >>> 4); product 25-bit signed, arithmetic shift truncates toward -inf; saturate to [-32768,32767].
// - S2/S3 (adder tree, 2 regs): 8 lanes -> 19-bit signed block sum; valid bit pipelined alongside; invalid cycles carry no data.
// - S4 integrator: dec_log2 (clamped) latched at the first block of each window; mid-window changes apply to the next window.
//   acc accumulates 2^D block sums; on the last block, result = sign-extend32(acc + sum), acc restarts at 0 with no lost block.
// - Latency: adc_valid with final block of a window -> m_valid high 5 cycles later (4 pipe regs + FIFO write), FIFO empty, no backpressure.
// - D=0: every valid input cycle produces one result.
// - Handshake: transfer when m_valid & m_ready; m_data stable while m_valid & !m_ready; m_valid independent of m_ready.
// - FIFO full + push + pop same cycle: both occur, no drop. Full + push, no pop: result dropped, overflow<=1.
// - overflow: set has priority over clear_overflow in the same cycle.
// - Peak: per valid cycle, a = max over lanes of |g| (|-32768| saturates to 32767); running peak = max(peak, a).
//   After interval_len valid cycles: interval_max <= max(peak, a), pulse interval_max_valid, peak reset to 0.
// - Peak path taps S1 output; interval_len is sampled when the interval counter is 0.
// STRUCTURE
// - rx_core_pkg: LANES=8, SAMPLE_W=16, GAIN_FRAC=4, BLOCK_W=19, RES_W=32; functions sat16(), abs_sat16().
// - Sub-module rx_result_fifo (synchronous FWFT, FIFO_DEPTH x 32, full/empty, simultaneous rd/wr). Gain, tree, integrator, peak stay inline.
// - Wrapper rx_core_wrapper exposes flat ports for the block design, as on the TX side.
// TESTING
// - Gain: all lanes 0x1000, rx_gain 0x10, D=0 -> m_data 0x00008000 per valid cycle, 5-cycle latency.
// - Saturation: lanes 0x7FFF/0x8000 alternating, rx_gain 0xFF -> g = 32767/-32768; block sum -4; interval_max 32767.
// - Decimation: lane0=1, others 0, D=3 -> one result of 8 per 8 valid cycles; gaps in adc_valid do not change count.
// - Backpressure: m_ready=0, D=0, 6 valid cycles -> 4 buffered, overflow=1 on 5th; drain yields first 4 in order.
// - Full boundary: with FIFO full, push+pop same cycle -> no drop, overflow unchanged.
// - Peak/reset: interval_len=0 -> pulse every valid cycle; interval_len=3, peak at cycle 2 -> reported once.
// - Peak/reset: reset mid-interval -> interval_max 0 and no stale pulse.
// - dec_log2 2->0 mid-window -> current window completes with 4 blocks.

Source files
------------

// File: rtl/rx_core_pkg.sv
// Shared widths and saturation helpers for the RF-ADC receive datapath.
package rx_core_pkg;

  localparam int LANES     = 8;
  localparam int SAMPLE_W  = 16;
  localparam int GAIN_FRAC = 4;
  localparam int BLOCK_W   = 19;
  localparam int RES_W     = 32;
  localparam int PROD_W    = SAMPLE_W + 9;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [PROD_W-1:0]   prod_t;

  // Drop the Q4.4 fraction (floor) and clamp into the 16-bit sample range.
  function automatic sample_t sat16(input prod_t prod);
    prod_t shifted;
    shifted = prod >>> GAIN_FRAC;
    if (shifted > prod_t'(32767)) begin
      return sample_t'(32767);
    end else if (shifted < prod_t'(-32768)) begin
      return sample_t'(-32768);
    end else begin
      return shifted[SAMPLE_W-1:0];
    end
  endfunction

  function automatic logic [SAMPLE_W-1:0] abs_sat16(input sample_t s);
    if (s == sample_t'(-32768)) begin
      return 16'h7FFF;
    end else if (s[SAMPLE_W-1]) begin
      return -s;
    end else begin
      return s;
    end
  endfunction

endpackage

// File: rtl/rx_result_fifo.sv
// First-word-fall-through result FIFO; a write into a full FIFO is accepted
// only when a read retires an entry in the same cycle.
module rx_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wrEn_i,
  input  logic [WIDTH-1:0] wrData_i,
  input  logic             rdEn_i,
  output logic [WIDTH-1:0] rdData_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, rdPtr_q;
  logic [AW:0]      count_q, count_d;
  logic             doWrite, doRead;

  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == (AW+1)'(DEPTH));
  assign doRead   = rdEn_i && !empty_o;
  assign doWrite  = wrEn_i && (!full_o || doRead);
  assign rdData_o = empty_o ? '0 : mem_q[rdPtr_q];

  always_comb begin
    count_d = count_q;
    case ({doWrite, doRead})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doWrite) wrPtr_q <= wrPtr_q + AW'(1);
      if (doRead)  rdPtr_q <= rdPtr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (doWrite) mem_q[wrPtr_q] <= wrData_i;
  end

endmodule

// File: rtl/rx_core.sv
// RF-ADC receive core: gain, 8-lane block sum, boxcar decimator into a result
// FIFO, plus a per-interval peak-magnitude monitor tapped after the gain stage.
module rx_core
  import rx_core_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int MAX_DEC_LOG2 = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [7:0]   rx_gain,
  input  logic [3:0]   dec_log2,
  input  logic [15:0]  interval_len,
  input  logic         clear_overflow,
  input  logic [127:0] adc_data,
  input  logic         adc_valid,
  output logic [31:0]  m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         overflow,
  output logic [15:0]  interval_max,
  output logic         interval_max_valid
);

  localparam int CNT_W = MAX_DEC_LOG2 + 1;

  sample_t                     gained_d [LANES];
  sample_t                     gained_q [LANES];
  logic signed [SAMPLE_W:0]    pairSum_d [LANES/2];
  logic signed [SAMPLE_W:0]    pairSum_q [LANES/2];
  logic signed [BLOCK_W-1:0]   blockSum_d, blockSum_q;
  logic                        s1Valid_q, s2Valid_q, s3Valid_q;
  prod_t                       laneExt, gainExt;

  logic signed [RES_W-1:0]     acc_q, acc_d, result_q, result_d, blockExt;
  logic [CNT_W-1:0]            blkCnt_q, blkCnt_d, winLast;
  logic [3:0]                  winD_q, winD_d, dClamp, dCur;
  logic                        resValid_q, resValid_d;

  logic [15:0]                 peak_q, peak_d, laneMax, laneAbs, peakNew;
  logic [15:0]                 ivCnt_q, ivCnt_d, ivLen_q, ivLen_d, lenCur;
  logic [15:0]                 intervalMax_q, intervalMax_d;
  logic                        intervalMaxValid_d, intervalMaxValid_q;
  logic                        overflow_q, overflow_d;
  logic                        fifoFull, fifoEmpty;

  always_comb begin
    laneExt = '0;
    gainExt = prod_t'({1'b0, rx_gain});
    for (int k = 0; k < LANES; k++) begin
      laneExt     = prod_t'($signed(adc_data[SAMPLE_W*k +: SAMPLE_W]));
      gained_d[k] = sat16(laneExt * gainExt);
    end
    for (int i = 0; i < LANES/2; i++) begin
      pairSum_d[i] = {gained_q[2*i][SAMPLE_W-1], gained_q[2*i]}
                   + {gained_q[2*i+1][SAMPLE_W-1], gained_q[2*i+1]};
    end
    blockSum_d = {{2{pairSum_q[0][SAMPLE_W]}}, pairSum_q[0]}
               + {{2{pairSum_q[1][SAMPLE_W]}}, pairSum_q[1]}
               + {{2{pairSum_q[2][SAMPLE_W]}}, pairSum_q[2]}
               + {{2{pairSum_q[3][SAMPLE_W]}}, pairSum_q[3]};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      gained_q   <= '{default: '0};
      pairSum_q  <= '{default: '0};
      blockSum_q <= '0;
      s1Valid_q  <= 1'b0;
      s2Valid_q  <= 1'b0;
      s3Valid_q  <= 1'b0;
    end else begin
      s1Valid_q <= adc_valid;
      s2Valid_q <= s1Valid_q;
      s3Valid_q <= s2Valid_q;
      if (adc_valid) gained_q   <= gained_d;
      if (s1Valid_q) pairSum_q  <= pairSum_d;
      if (s2Valid_q) blockSum_q <= blockSum_d;
    end
  end

  // Window length is frozen at the first block so a mid-window change waits.
  always_comb begin
    dClamp     = (dec_log2 > 4'(MAX_DEC_LOG2)) ? 4'(MAX_DEC_LOG2) : dec_log2;
    dCur       = (blkCnt_q == '0) ? dClamp : winD_q;
    winLast    = (CNT_W'(1) << dCur) - CNT_W'(1);
    blockExt   = {{(RES_W-BLOCK_W){blockSum_q[BLOCK_W-1]}}, blockSum_q};
    acc_d      = acc_q;
    blkCnt_d   = blkCnt_q;
    winD_d     = winD_q;
    result_d   = result_q;
    resValid_d = 1'b0;
    if (s3Valid_q) begin
      winD_d = dCur;
      if (blkCnt_q == winLast) begin
        result_d   = acc_q + blockExt;
        resValid_d = 1'b1;
        acc_d      = '0;
        blkCnt_d   = '0;
      end else begin
        acc_d    = acc_q + blockExt;
        blkCnt_d = blkCnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    laneMax = '0;
    laneAbs = '0;
    for (int k = 0; k < LANES; k++) begin
      laneAbs = abs_sat16(gained_q[k]);
      if (laneAbs > laneMax) laneMax = laneAbs;
    end
    peakNew            = (laneMax > peak_q) ? laneMax : peak_q;
    lenCur             = (ivCnt_q != '0) ? ivLen_q :
                         ((interval_len == '0) ? 16'd1 : interval_len);
    peak_d             = peak_q;
    ivCnt_d            = ivCnt_q;
    ivLen_d            = ivLen_q;
    intervalMax_d      = intervalMax_q;
    intervalMaxValid_d = 1'b0;
    if (s1Valid_q) begin
      ivLen_d = lenCur;
      if (ivCnt_q == lenCur - 16'd1) begin
        intervalMax_d      = peakNew;
        intervalMaxValid_d = 1'b1;
        peak_d             = '0;
        ivCnt_d            = '0;
      end else begin
        peak_d  = peakNew;
        ivCnt_d = ivCnt_q + 16'd1;
      end
    end
  end

  // A result is lost only when the FIFO is full and nothing drains this cycle.
  always_comb begin
    overflow_d = overflow_q;
    if (resValid_q && fifoFull && !m_ready) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q              <= '0;
      blkCnt_q           <= '0;
      winD_q             <= '0;
      result_q           <= '0;
      resValid_q         <= 1'b0;
      peak_q             <= '0;
      ivCnt_q            <= '0;
      ivLen_q            <= '0;
      intervalMax_q      <= '0;
      intervalMaxValid_q <= 1'b0;
      overflow_q         <= 1'b0;
    end else begin
      acc_q              <= acc_d;
      blkCnt_q           <= blkCnt_d;
      winD_q             <= winD_d;
      result_q           <= result_d;
      resValid_q         <= resValid_d;
      peak_q             <= peak_d;
      ivCnt_q            <= ivCnt_d;
      ivLen_q            <= ivLen_d;
      intervalMax_q      <= intervalMax_d;
      intervalMaxValid_q <= intervalMaxValid_d;
      overflow_q         <= overflow_d;
    end
  end

  rx_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RES_W)
  ) resultFifo (
    .clock    (clock),
    .reset    (reset),
    .wrEn_i   (resValid_q),
    .wrData_i (result_q),
    .rdEn_i   (m_ready),
    .rdData_o (m_data),
    .empty_o  (fifoEmpty),
    .full_o   (fifoFull)
  );

  assign m_valid            = !fifoEmpty;
  assign overflow           = overflow_q;
  assign interval_max       = intervalMax_q;
  assign interval_max_valid = intervalMaxValid_q;

endmodule

// File: tb/tb_rx_core.sv
// Scoreboard bench for rx_core: directed vectors push expected results/peaks,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_rx_core;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   rx_gain;
  logic [3:0]   dec_log2;
  logic [15:0]  interval_len;
  logic         clear_overflow;
  logic [127:0] adc_data;
  logic         adc_valid;
  logic [31:0]  m_data;
  logic         m_valid;
  logic         m_ready;
  logic         overflow;
  logic [15:0]  interval_max;
  logic         interval_max_valid;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] expQ[$];
  logic [15:0] peakQ[$];

  always #5 clock = ~clock;

  rx_core #(
    .FIFO_DEPTH   (4),
    .MAX_DEC_LOG2 (10)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .rx_gain            (rx_gain),
    .dec_log2           (dec_log2),
    .interval_len       (interval_len),
    .clear_overflow     (clear_overflow),
    .adc_data           (adc_data),
    .adc_valid          (adc_valid),
    .m_data             (m_data),
    .m_valid            (m_valid),
    .m_ready            (m_ready),
    .overflow           (overflow),
    .interval_max       (interval_max),
    .interval_max_valid (interval_max_valid)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic logic [127:0] laneVec(input int idx, input logic [15:0] v);
    logic [127:0] r;
    r = '0;
    r[16*idx +: 16] = v;
    return r;
  endfunction

  task automatic applyStimulus(input logic [127:0] data, input logic valid);
    @(posedge clock);
    #1;
    adc_data  = data;
    adc_valid = valid;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus('0, 1'b0);
  endtask

  task automatic doReset();
    @(posedge clock);
    #1;
    reset     = 1'b1;
    adc_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("rst_m_valid", 32'(m_valid), 0);
    checkOutput("rst_m_data", m_data, 0);
    checkOutput("rst_overflow", 32'(overflow), 0);
    checkOutput("rst_interval_max", 32'(interval_max), 0);
    checkOutput("rst_interval_max_valid", 32'(interval_max_valid), 0);
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while ((expQ.size() != 0 || peakQ.size() != 0 || m_valid) && n < 60) begin
      idle(1);
      n++;
    end
    checkOutput({name, "_pending"}, 32'(expQ.size() + peakQ.size()), 0);
    checkOutput({name, "_m_valid_idle"}, 32'(m_valid), 0);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (m_valid && m_ready) begin
        checkOutput("result_expected", 32'(expQ.size() > 0), 1);
        if (expQ.size() > 0) checkOutput("m_data", m_data, expQ.pop_front());
      end
      if (interval_max_valid) begin
        checkOutput("peak_expected", 32'(peakQ.size() > 0), 1);
        if (peakQ.size() > 0) checkOutput("interval_max", 32'(interval_max), 32'(peakQ.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    rx_gain        = 8'h10;
    dec_log2       = 4'd0;
    interval_len   = 16'hFFFF;
    clear_overflow = 1'b0;
    adc_data       = '0;
    adc_valid      = 1'b0;
    m_ready        = 1'b1;
    doReset();

    // Unity gain, D=0: 8 x 0x1000 -> 0x8000 each valid cycle, 5-cycle latency.
    repeat (4) expQ.push_back(32'h0000_8000);
    applyStimulus({8{16'h1000}}, 1'b1);
    lat = 0;
    do begin
      applyStimulus('0, 1'b0);
      lat++;
    end while (!m_valid && lat < 20);
    checkOutput("gain_latency", 32'(lat), 5);
    repeat (3) applyStimulus({8{16'h1000}}, 1'b1);
    waitDrain("gain");

    // Saturation both ways: 4*32767 + 4*(-32768) = -4, peak 32767.
    rx_gain      = 8'hFF;
    interval_len = 16'd1;
    doReset();
    expQ.push_back(32'hFFFF_FFFC);
    peakQ.push_back(16'h7FFF);
    applyStimulus({4{16'h8000, 16'h7FFF}}, 1'b1);
    waitDrain("sat");
    checkOutput("sat_interval_max_held", 32'(interval_max), 32'h7FFF);

    // D=3 with gaps: 16 valid cycles of lane0=1 -> two results of 8.
    rx_gain      = 8'h10;
    dec_log2     = 4'd3;
    interval_len = 16'hFFFF;
    doReset();
    expQ.push_back(32'd8);
    expQ.push_back(32'd8);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(laneVec(0, 16'd1), 1'b1);
      if (i % 3 == 0) idle(2);
    end
    waitDrain("decim");

    // Backpressure: 6 results into depth 4; 5th drop sets overflow even with clear.
    dec_log2 = 4'd0;
    doReset();
    m_ready = 1'b0;
    for (int k = 1; k <= 4; k++) expQ.push_back(32'(k));
    for (int k = 1; k <= 6; k++) applyStimulus(laneVec(0, 16'(k)), 1'b1);
    idle(3);
    checkOutput("ovf_before_5th", 32'(overflow), 0);
    clear_overflow = 1'b1;
    idle(1);
    clear_overflow = 1'b0;
    checkOutput("ovf_set_beats_clear", 32'(overflow), 1);
    idle(3);
    checkOutput("bp_m_valid", 32'(m_valid), 1);
    checkOutput("bp_ovf_sticky", 32'(overflow), 1);
    m_ready = 1'b1;
    waitDrain("bp");
    clear_overflow = 1'b1;
    idle(1);
    clear_overflow = 1'b0;
    checkOutput("ovf_cleared", 32'(overflow), 0);

    // Full FIFO with push and pop in the same cycle: nothing lost.
    doReset();
    m_ready = 1'b0;
    for (int k = 1; k <= 5; k++) expQ.push_back(32'(k));
    for (int k = 1; k <= 4; k++) applyStimulus(laneVec(0, 16'(k)), 1'b1);
    idle(8);
    checkOutput("full_m_valid", 32'(m_valid), 1);
    applyStimulus(laneVec(0, 16'd5), 1'b1);
    idle(4);
    m_ready = 1'b1;
    idle(1);
    m_ready = 1'b0;
    checkOutput("full_pushpop_ovf", 32'(overflow), 0);
    checkOutput("full_pushpop_m_valid", 32'(m_valid), 1);
    idle(3);
    m_ready = 1'b1;
    waitDrain("full");
    checkOutput("full_ovf_final", 32'(overflow), 0);

    // Peak with interval_len=0: one pulse per valid cycle, |-32768| -> 32767.
    interval_len = 16'd0;
    doReset();
    expQ.push_back(32'hFFFF_FED4); peakQ.push_back(16'd300);
    expQ.push_back(32'd5);         peakQ.push_back(16'd5);
    expQ.push_back(32'hFFFF_8000); peakQ.push_back(16'h7FFF);
    applyStimulus(laneVec(2, 16'hFED4), 1'b1);
    applyStimulus(laneVec(5, 16'd5), 1'b1);
    applyStimulus(laneVec(7, 16'h8000), 1'b1);
    waitDrain("peak0");

    // interval_len=3: peak in the middle reported once, then peak restarts.
    interval_len = 16'd3;
    expQ.push_back(32'd10);
    expQ.push_back(32'd900);
    expQ.push_back(32'd20);
    peakQ.push_back(16'd900);
    expQ.push_back(32'd1);
    expQ.push_back(32'd2);
    expQ.push_back(32'd3);
    peakQ.push_back(16'd3);
    applyStimulus(laneVec(0, 16'd10), 1'b1);
    applyStimulus(laneVec(0, 16'd900), 1'b1);
    applyStimulus(laneVec(0, 16'd20), 1'b1);
    applyStimulus(laneVec(0, 16'd1), 1'b1);
    applyStimulus(laneVec(0, 16'd2), 1'b1);
    applyStimulus(laneVec(0, 16'd3), 1'b1);
    waitDrain("peak3");

    // Reset mid-interval: partial peak and in-flight results vanish.
    interval_len = 16'd5;
    applyStimulus(laneVec(0, 16'd1000), 1'b1);
    applyStimulus(laneVec(0, 16'd1000), 1'b1);
    doReset();
    idle(8);
    checkOutput("rstmid_interval_max", 32'(interval_max), 0);
    interval_len = 16'd2;
    expQ.push_back(32'd50);
    expQ.push_back(32'd30);
    peakQ.push_back(16'd50);
    applyStimulus(laneVec(0, 16'd50), 1'b1);
    applyStimulus(laneVec(0, 16'd30), 1'b1);
    waitDrain("rstmid");

    // dec_log2 2->0 after the window opened: 1+2+3+4 = 10, then 5 and 6 alone.
    dec_log2     = 4'd2;
    interval_len = 16'hFFFF;
    doReset();
    expQ.push_back(32'd10);
    expQ.push_back(32'd5);
    expQ.push_back(32'd6);
    for (int k = 1; k <= 4; k++) applyStimulus(laneVec(0, 16'(k)), 1'b1);
    applyStimulus(laneVec(0, 16'd5), 1'b1);
    dec_log2 = 4'd0;
    applyStimulus(laneVec(0, 16'd6), 1'b1);
    waitDrain("declog");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
